// File: rtl/seq01246_pkg.sv
// Shared types and constants for the 0,1,2,4,6 sequence tracker and its decoder.
package seq01246_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [2:0] C0 = 3'd0;
   localparam logic [2:0] C1 = 3'd1;
   localparam logic [2:0] C2 = 3'd2;
   localparam logic [2:0] C4 = 3'd4;
   localparam logic [2:0] C6 = 3'd6;

   localparam int         SEQ_LEN  = 5;
   localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);

   function automatic logic [2:0] next_idx(input logic [2:0] idx);
      return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/seq01246_decode.sv
// Combinational code -> sequence-index decoder; codes 3, 5 and 7 are not legal.
module seq01246_decode
   import seq01246_pkg::*;
(
   input  logic [2:0] code_in,
   output logic       legal,
   output logic [2:0] idx
);

   always_comb begin
      legal = 1'b1;
      idx   = 3'd0;
      case (code_in)
         C0:      idx = 3'd0;
         C1:      idx = 3'd1;
         C2:      idx = 3'd2;
         C4:      idx = 3'd3;
         C6:      idx = 3'd4;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seq01246_tracker.sv
// Receive-side tracker: hunts, syncs and locks onto the 0,1,2,4,6 code stream,
// flywheeling through isolated errors. All outputs come straight from flops.
module seq01246_tracker
   import seq01246_pkg::*;
#(
   parameter int LOCK_CNT   = 3,
   parameter int MISS_LIMIT = 2,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       code_in,
   input  logic             code_valid,
   output logic [2:0]       index,
   output logic             locked,
   output logic             err_illegal,
   output logic             err_order,
   output logic             wrap_pulse,
   output logic [ERR_W-1:0] err_count
);

   localparam int             GW       = $clog2(LOCK_CNT + 1);
   localparam int             MW       = $clog2(MISS_LIMIT + 1);
   localparam logic [GW-1:0]  LOCK_V   = GW'(LOCK_CNT);
   localparam logic [MW-1:0]  MISS_V   = MW'(MISS_LIMIT);

   logic             legal;
   logic [2:0]       idx;
   logic [2:0]       exp_idx;
   logic             in_order;

   state_t           state_q, state_d;
   logic [2:0]       last_idx_q, last_idx_d;
   logic [GW-1:0]    good_cnt_q, good_cnt_d;
   logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             locked_q, locked_d;
   logic             err_illegal_q, err_illegal_d;
   logic             err_order_q, err_order_d;
   logic             wrap_q, wrap_d;

   seq01246_decode u_decode (
      .code_in (code_in),
      .legal   (legal),
      .idx     (idx)
   );

   assign exp_idx  = next_idx(last_idx_q);
   assign in_order = legal && (idx == exp_idx);

   always_comb begin
      state_d       = state_q;
      last_idx_d    = last_idx_q;
      good_cnt_d    = good_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      err_cnt_d     = err_cnt_q;
      err_illegal_d = 1'b0;
      err_order_d   = 1'b0;
      wrap_d        = 1'b0;
      if (code_valid) begin
         case (state_q)
            HUNT: begin
               if (legal) begin
                  last_idx_d = idx;
                  good_cnt_d = GW'(1);
                  if (LOCK_CNT == 1) begin
                     state_d    = LOCKED;
                     miss_cnt_d = '0;
                  end else begin
                     state_d = SYNC;
                  end
               end else begin
                  err_illegal_d = 1'b1;
               end
            end
            SYNC: begin
               if (!legal) begin
                  err_illegal_d = 1'b1;
                  state_d       = HUNT;
               end else if (in_order) begin
                  last_idx_d = idx;
                  good_cnt_d = good_cnt_q + GW'(1);
                  if (good_cnt_q + GW'(1) == LOCK_V) begin
                     state_d    = LOCKED;
                     miss_cnt_d = '0;
                  end
               end else begin
                  // out-of-order legal code simply starts a new run
                  last_idx_d = idx;
                  good_cnt_d = GW'(1);
               end
            end
            LOCKED: begin
               if (in_order) begin
                  last_idx_d = idx;
                  miss_cnt_d = '0;
                  wrap_d     = (idx == 3'd0);
               end else begin
                  err_illegal_d = !legal;
                  err_order_d   = legal;
                  err_cnt_d     = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
                  last_idx_d    = exp_idx;
                  if (miss_cnt_q + MW'(1) == MISS_V) begin
                     state_d    = HUNT;
                     miss_cnt_d = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + MW'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= HUNT;
         last_idx_q    <= 3'd0;
         good_cnt_q    <= '0;
         miss_cnt_q    <= '0;
         err_cnt_q     <= '0;
         locked_q      <= 1'b0;
         err_illegal_q <= 1'b0;
         err_order_q   <= 1'b0;
         wrap_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_idx_q    <= last_idx_d;
         good_cnt_q    <= good_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         err_cnt_q     <= err_cnt_d;
         locked_q      <= locked_d;
         err_illegal_q <= err_illegal_d;
         err_order_q   <= err_order_d;
         wrap_q        <= wrap_d;
      end
   end

   assign index       = last_idx_q;
   assign locked      = locked_q;
   assign err_illegal = err_illegal_q;
   assign err_order   = err_order_q;
   assign wrap_pulse  = wrap_q;
   assign err_count   = err_cnt_q;

endmodule

// File: doc/seq01246_tracker.md
# seq01246_tracker

- Receive-side companion to the 0,1,2,4,6 arbitrary-sequence counter.
- Samples a 3-bit code stream and decodes each code to its sequence index (0–4).
- Acquires lock after a run of in-order codes, flywheels through isolated errors, and drops back to hunting after repeated errors.
- Used at the consuming end of a link carrying the counter output, to recover position and flag corruption.

## Interface
- LOCK_CNT, default 3: consecutive in-order legal samples (including the first) required to assert lock; legal range ≥1.
- MISS_LIMIT, default 2: consecutive bad samples while locked that force loss of lock; legal range ≥1.
- ERR_W, default 8: width of the saturating error counter.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- code_in  in  3  code from the transmitting counter.
- code_valid  in  1  code_in is sampled only on edges where this is 1.
- index  out  3  decoded index of the last accepted or flywheeled sample.
- locked  out  1  tracker is in LOCKED.
- err_illegal  out  1  one-cycle pulse: the sampled code was 3, 5 or 7.
- err_order  out  1  one-cycle pulse: legal code, but not the expected successor, while locked.
- wrap_pulse  out  1  one-cycle pulse: in-order transition from index 4 to index 0 accepted while locked.
- err_count  out  ERR_W  errors counted while locked; saturates at all-ones.

## Operation
- Decode map (code → index): 0→0, 1→1, 2→2, 4→3, 6→4. Codes 3, 5 and 7 are illegal.
- Expected next index: 0 if last_idx = 4, else last_idx+1.
- Internal registers: last_idx (drives index), good_cnt, miss_cnt.
- Edges with code_valid=0: all state and registers hold; all pulses are 0.
- HUNT:
  - Legal sample: last_idx←idx, good_cnt←1. Go to LOCKED if LOCK_CNT=1, else SYNC.
  - Illegal sample: err_illegal pulse, stay in HUNT; err_count unchanged.
- SYNC:
  - Legal, in-order sample: last_idx←idx, good_cnt+1. On reaching LOCK_CNT: go to LOCKED, miss_cnt←0.
  - Legal, out-of-order sample: restart the run with last_idx←idx, good_cnt←1. No error pulse.
  - Illegal sample: err_illegal pulse, go to HUNT.
- LOCKED:
  - In-order sample: last_idx←idx, miss_cnt←0. Pulse wrap_pulse if idx=0.
  - Bad sample (illegal or out-of-order):
    - Pulse err_illegal or err_order; err_count+1, saturating.
    - Flywheel: last_idx←expected; wrap_pulse is not asserted.
    - miss_cnt+1. On reaching MISS_LIMIT: go to HUNT with locked=0 and miss_cnt←0; last_idx still takes the flywheel value.
- Reset values: index 0, locked 0, all pulses 0, err_count 0, state HUNT, good_cnt 0, miss_cnt 0.
- Reset has priority over code_valid.
- err_count is cleared only by reset.

## Timing
- All outputs are registered.
- A sample taken on edge k is reflected on every output from edge k until edge k+1.
- With LOCK_CNT=3 and valid codes 0,1,2 on consecutive edges, locked rises after the third edge.
- locked falls after the edge that takes the MISS_LIMIT-th consecutive bad sample.
- Pulses last exactly one cycle, even when errors arrive back-to-back (each valid edge produces its own pulse).
- No combinational path from any input to any output.

## Structure
- Package seq01246_pkg holds:
  - state enum {HUNT, SYNC, LOCKED}
  - code constants C0=0, C1=1, C2=2, C4=4, C6=6
  - SEQ_LEN=5, LAST_IDX=4
- Sub-module seq01246_decode: combinational, code_in → {legal, idx[2:0]}, shared with any future checker.
- The top level holds the FSM, the counters and the output registers.

## Test plan
- Lock and wrap: reset, then codes 0,1,2,4,6,0 on consecutive valid edges → locked rises after the 3rd edge; index sequence 0,1,2,3,4,0; wrap_pulse on the final edge only.
- Single illegal code while locked: after 0,1,2,4, send 5 then 0 → err_illegal pulse, err_count=1, index=4 (flywheel), locked stays 1; the next sample 0 is in order, wrap_pulse=1, miss_cnt clears.
- Loss of lock: after 0,1,2, send 2,2 → two err_order pulses, err_count=2, locked falls after the second edge, state HUNT; then 0,1,2 relocks.
- Valid gaps: codes 0,1 then code_valid=0 for 4 cycles with code_in=7, then 2 → no pulses during the gap; locked rises on the edge that takes 2.
- Mid-sequence acquisition and SYNC restart: codes 4,6,2,4,6,0 → run restarts at 2 (no pulse); locked after 6; wrap_pulse on 0.
- Saturation and reset: ERR_W=2 with 5 errors spread so lock is never lost → err_count sticks at 3. Assert reset mid-stream → all outputs return to reset values on the next edge.
